counter_checker: RTL and testbench

//  Passive in-circuit checker for the enable-gated up-counter (clk/rst_n/en/count).

---
 rtl/counter_pkg.sv | 28 ++
 rtl/counter_model.sv | 48 ++++
 rtl/counter_checker.sv | 157 +++++++++++++++
 tb/tb_counter_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared types and helpers for the counter checker slice.
//   chk_state_e  - checker FSM states
//   DEF_*        - default parameter values for the checker and its model
//   next_count() - enable-gated wrap-add used to predict the next count
package counter_pkg;

  typedef enum logic [1:0] {
    SYNC     = 2'd0,
    TRACK    = 2'd1,
    ERR_HOLD = 2'd2
  } chk_state_e;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_ERR_W   = 8;
  localparam int unsigned DEF_RST_VAL = 0;

  // cnt + en, truncated to 'width' bits (carry out discarded, so it wraps)
  function automatic logic [31:0] next_count(input logic [31:0] cnt,
                                             input logic        en,
                                             input int unsigned width);
    logic [31:0] sum;
    logic [31:0] mask;
    sum  = cnt + {31'd0, en};
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return sum & mask;
  endfunction

endpackage

// File: rtl/counter_model.sv
// counter_model: reference model of the enable-gated up-counter.
// Registers the previous observed count/enable and predicts the next count.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cnt_in      - observed counter value (sampled every clock)
//   en_in       - observed counter enable (sampled every clock)
//   exp_cnt     - predicted value of cnt_in for the current sample
//   wrap_det    - current sample is a legal wrap all-ones -> 0
module counter_model
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned RST_VAL = DEF_RST_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             en_in,
  output logic [WIDTH-1:0] exp_cnt,
  output logic             wrap_det
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] prev_cnt_q, prev_cnt_d;
  logic             prev_en_q,  prev_en_d;

  // The model always follows the observed counter; after a mismatch this is
  // exactly the resync that keeps a single glitch from cascading into errors.
  always_comb begin
    prev_cnt_d = cnt_in;
    prev_en_d  = en_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cnt_q <= RST_CNT;
      prev_en_q  <= 1'b0;
    end else begin
      prev_cnt_q <= prev_cnt_d;
      prev_en_q  <= prev_en_d;
    end
  end

  assign exp_cnt  = WIDTH'(next_count(32'(prev_cnt_q), prev_en_q, WIDTH));
  assign wrap_det = (prev_cnt_q == '1) && prev_en_q && (cnt_in == '0);

endmodule

// File: rtl/counter_checker.sv
// counter_checker: passive checker for an enable-gated up-counter.
// Predicts each sample of count_obs from the previous sample and reports
// mismatches as a pulse, a sticky flag, a saturating count and a capture of
// the first failing expected/actual pair.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en_obs      - observed counter enable
//   count_obs   - observed counter value
//   clear       - synchronous clear of all error state, FSM back to SYNC
//   exp_count   - model's expected count for the current sample
//   err_pulse   - one cycle after each mismatching sample
//   err_sticky  - set on first mismatch, held until reset/clear
//   err_cnt     - saturating mismatch count
//   first_exp   - expected value at the first mismatch
//   first_act   - observed value at the first mismatch
//   wrap_pulse  - one cycle after an observed legal wrap
//   locked      - FSM is tracking (TRACK or ERR_HOLD)
module counter_checker
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ERR_W   = DEF_ERR_W,
  parameter int unsigned RST_VAL = DEF_RST_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_obs,
  input  logic [WIDTH-1:0] count_obs,
  input  logic             clear,
  output logic [WIDTH-1:0] exp_count,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act,
  output logic             wrap_pulse,
  output logic             locked
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  chk_state_e       state_q,      state_d;
  logic             from_rst_q,   from_rst_d;   // SYNC was entered via reset
  logic             err_pulse_q,  err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0] err_cnt_q,    err_cnt_d;
  logic [WIDTH-1:0] first_exp_q,  first_exp_d;
  logic [WIDTH-1:0] first_act_q,  first_act_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             locked_q,     locked_d;

  logic [WIDTH-1:0] model_exp;
  logic             wrap_det;
  logic             mismatch;
  logic [WIDTH-1:0] ref_val;

  counter_model #(
    .WIDTH  (WIDTH),
    .RST_VAL(RST_VAL)
  ) u_model (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_in  (count_obs),
    .en_in   (en_obs),
    .exp_cnt (model_exp),
    .wrap_det(wrap_det)
  );

  always_comb begin
    state_d      = state_q;
    from_rst_d   = from_rst_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    first_exp_d  = first_exp_q;
    first_act_d  = first_act_q;
    wrap_pulse_d = 1'b0;
    mismatch     = 1'b0;
    ref_val      = model_exp;

    case (state_q)
      SYNC: begin
        // Only the first sample after reset is checked against RST_VAL;
        // after a clear the first sample is simply adopted.
        ref_val    = RST_CNT;
        mismatch   = from_rst_q && (count_obs != RST_CNT);
        from_rst_d = 1'b0;
        state_d    = TRACK;
      end
      TRACK, ERR_HOLD: begin
        mismatch     = (count_obs != model_exp);
        wrap_pulse_d = wrap_det;
      end
      default: state_d = SYNC;
    endcase

    if (mismatch) begin
      err_pulse_d = 1'b1;
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
      if (!err_sticky_q) begin
        err_sticky_d = 1'b1;
        first_exp_d  = ref_val;
        first_act_d  = count_obs;
      end
      if (err_cnt_d == ERR_MAX) state_d = ERR_HOLD;
    end

    // clear overrides anything the current sample would have logged
    if (clear) begin
      state_d      = SYNC;
      from_rst_d   = 1'b0;
      err_pulse_d  = 1'b0;
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
      first_exp_d  = '0;
      first_act_d  = '0;
      wrap_pulse_d = 1'b0;
    end

    locked_d = (state_d != SYNC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      from_rst_q   <= 1'b1;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      first_exp_q  <= '0;
      first_act_q  <= '0;
      wrap_pulse_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      from_rst_q   <= from_rst_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      first_exp_q  <= first_exp_d;
      first_act_q  <= first_act_d;
      wrap_pulse_q <= wrap_pulse_d;
      locked_q     <= locked_d;
    end
  end

  assign exp_count  = model_exp;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign first_exp  = first_exp_q;
  assign first_act  = first_act_q;
  assign wrap_pulse = wrap_pulse_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker (WIDTH=4, ERR_W=8, RST_VAL=0).
// The driver applies one sample per clock and queues the outputs expected
// after that edge; the monitor pops and compares after every rising edge.
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_obs = 1'b0;
  logic [3:0] count_obs = 4'd0;
  logic       clear = 1'b0;
  logic [3:0] exp_count;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic [3:0] first_exp;
  logic [3:0] first_act;
  logic       wrap_pulse;
  logic       locked;

  counter_checker #(.WIDTH(4), .ERR_W(8), .RST_VAL(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_obs    (en_obs),
    .count_obs (count_obs),
    .clear     (clear),
    .exp_count (exp_count),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt),
    .first_exp (first_exp),
    .first_act (first_act),
    .wrap_pulse(wrap_pulse),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] exp_count;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_cnt;
    logic [3:0] first_exp;
    logic [3:0] first_act;
    logic       wrap_pulse;
    logic       locked;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.tag, ".exp_count"},  32'(exp_count),  32'(e.exp_count));
    chk({e.tag, ".err_pulse"},  32'(err_pulse),  32'(e.err_pulse));
    chk({e.tag, ".err_sticky"}, 32'(err_sticky), 32'(e.err_sticky));
    chk({e.tag, ".err_cnt"},    32'(err_cnt),    32'(e.err_cnt));
    chk({e.tag, ".first_exp"},  32'(first_exp),  32'(e.first_exp));
    chk({e.tag, ".first_act"},  32'(first_act),  32'(e.first_act));
    chk({e.tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(e.wrap_pulse));
    chk({e.tag, ".locked"},     32'(locked),     32'(e.locked));
  endtask

  // Monitor: compare after each rising edge whenever an expectation is queued
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk_all(mon_e);
      end
    end
  end

  // One sample: drive inputs, queue the outputs expected after the next edge
  task automatic step(input logic en, input logic [3:0] cnt, input logic clr,
                      input logic [3:0] x_exp, input logic pulse, input logic sticky,
                      input logic [7:0] ecnt, input logic [3:0] fe, input logic [3:0] fa,
                      input logic wrap, input logic lock, input string tag);
    en_obs    = en;
    count_obs = cnt;
    clear     = clr;
    sb_q.push_back('{exp_count: x_exp, err_pulse: pulse, err_sticky: sticky,
                     err_cnt: ecnt, first_exp: fe, first_act: fa,
                     wrap_pulse: wrap, locked: lock, tag: tag});
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    exp_t z;
    z = '{exp_count: 4'd0, err_pulse: 1'b0, err_sticky: 1'b0, err_cnt: 8'd0,
          first_exp: 4'd0, first_act: 4'd0, wrap_pulse: 1'b0, locked: 1'b0, tag: tag};
    chk_all(z);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset_init");
    rst_n = 1'b1;

    // 1: good counter, en=1, 20 samples; single wrap after 15 -> 0
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 4'(k), 1'b0, 4'(k + 1), 1'b0, 1'b0, 8'd0, 4'd0, 4'd0,
           (k == 16), 1'b1, "t1_count");
    end

    // 2: en pattern 1,0,0,1 (count 4,5,5,5); prediction holds on en=0
    step(1'b1, 4'd4, 1'b0, 4'd5, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t2_en1");
    step(1'b0, 4'd5, 1'b0, 4'd5, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t2_en0a");
    step(1'b0, 4'd5, 1'b0, 4'd5, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t2_en0b");
    step(1'b1, 4'd5, 1'b0, 4'd6, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t2_en1b");

    // 3: clear, resync at 3 (not checked after clear), then skip 5 -> 7
    step(1'b1, 4'd6, 1'b1, 4'd7, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b0, "t3_clear");
    step(1'b1, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t3_sync");
    step(1'b1, 4'd4, 1'b0, 4'd5, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t3_c4");
    step(1'b1, 4'd5, 1'b0, 4'd6, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t3_c5");
    step(1'b1, 4'd7, 1'b0, 4'd8, 1'b1, 1'b1, 8'd1, 4'd6, 4'd7, 1'b0, 1'b1, "t3_skip");
    step(1'b1, 4'd8, 1'b0, 4'd9, 1'b0, 1'b1, 8'd1, 4'd6, 4'd7, 1'b0, 1'b1, "t3_c8");
    step(1'b1, 4'd9, 1'b0, 4'd10, 1'b0, 1'b1, 8'd1, 4'd6, 4'd7, 1'b0, 1'b1, "t3_c9");

    // 4: reset, first sample 3 instead of RST_VAL 0
    rst_n = 1'b0;
    #1;
    chk_reset("t4_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd3, 1'b0, 4'd4, 1'b1, 1'b1, 8'd1, 4'd0, 4'd3, 1'b0, 1'b1, "t4_first");
    step(1'b1, 4'd4, 1'b0, 4'd5, 1'b0, 1'b1, 8'd1, 4'd0, 4'd3, 1'b0, 1'b1, "t4_c4");

    // 5: stuck count with en=1 -> mismatch every sample, saturates at 255
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'd4, 1'b0, 4'd5, 1'b1, 1'b1, ((i + 2) > 255) ? 8'd255 : 8'(i + 2),
           4'd0, 4'd3, 1'b0, 1'b1, "t5_stuck");
    end
    step(1'b1, 4'd5, 1'b0, 4'd6, 1'b0, 1'b1, 8'd255, 4'd0, 4'd3, 1'b0, 1'b1, "t5_good");
    step(1'b1, 4'd7, 1'b0, 4'd8, 1'b1, 1'b1, 8'd255, 4'd0, 4'd3, 1'b0, 1'b1, "t5_hold_err");

    // 6: clear on a mismatching sample, resync, then async reset mid-count
    step(1'b1, 4'd12, 1'b1, 4'd13, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b0, "t6_clear_mm");
    step(1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t6_sync");
    step(1'b1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t6_c1");
    step(1'b1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t6_c2");
    count_obs = 4'd3;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6_async_rst");
    @(posedge clk);
    #1;
    chk_reset("t6_rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t6_resync");
    step(1'b1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, "t6_c1b");

    @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
